// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and multiply results
// wait in a FIFO. A starvation counter forces a one-cycle pipeline stall so the FIFO head can write.
module wb_port_arbiter #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_pipe_reg_write,
    input  logic [4:0]       i_pipe_write_reg,
    input  logic [31:0]      i_pipe_write_data,
    input  logic             i_mul_valid,
    output logic             o_mul_ready,
    input  logic [4:0]       i_mul_write_reg,
    input  logic [31:0]      i_mul_write_data,
    output logic             o_stall_pipe,
    output logic             o_rf_write_en,
    output logic [4:0]       o_rf_write_reg,
    output logic [31:0]      o_rf_write_data,
    output logic             o_grant_mul,
    output logic [CNT_W-1:0] o_fifo_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]       r_mem_reg  [DEPTH];
    logic [31:0]      r_mem_data [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_rf_write_en;
    logic [4:0]       r_rf_write_reg;
    logic [31:0]      r_rf_write_data;
    logic             r_grant_mul;

    logic             w_not_empty;
    logic             w_stall;
    logic             w_grant_pipe;
    logic             w_grant_fifo;
    logic             w_push;
    logic [4:0]       w_head_reg;
    logic [31:0]      w_head_data;

    always_comb begin
        w_not_empty  = (r_count != '0);
        w_stall      = w_not_empty && (r_wait_cnt == CNT_W'(MAX_WAIT));
        w_grant_pipe = i_pipe_reg_write && !w_stall;
        w_grant_fifo = !w_grant_pipe && w_not_empty;
        // Ready is taken from registered occupancy only, so a full FIFO stays closed even
        // in the cycle that it pops.
        o_mul_ready  = (r_count != CNT_W'(DEPTH));
        w_push       = i_mul_valid && o_mul_ready;
        w_head_reg   = r_mem_reg[r_rd_ptr];
        w_head_data  = r_mem_data[r_rd_ptr];
    end

    always_ff @(posedge i_clock) begin
        if (w_push && !i_reset) begin
            r_mem_reg[r_wr_ptr]  <= i_mul_write_reg;
            r_mem_data[r_wr_ptr] <= i_mul_write_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_grant_fifo) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_grant_fifo) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_grant_fifo) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Counts cycles the current head has been passed over; restarts for each new head.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wait_cnt <= '0;
        end else if (!w_not_empty || w_grant_fifo) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != CNT_W'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // Writes to $0 still consume the grant but never raise the enable.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rf_write_en   <= 1'b0;
            r_rf_write_reg  <= '0;
            r_rf_write_data <= '0;
            r_grant_mul     <= 1'b0;
        end else if (w_grant_pipe) begin
            r_rf_write_en   <= (i_pipe_write_reg != 5'd0);
            r_rf_write_reg  <= i_pipe_write_reg;
            r_rf_write_data <= i_pipe_write_data;
            r_grant_mul     <= 1'b0;
        end else if (w_grant_fifo) begin
            r_rf_write_en   <= (w_head_reg != 5'd0);
            r_rf_write_reg  <= w_head_reg;
            r_rf_write_data <= w_head_data;
            r_grant_mul     <= 1'b1;
        end else begin
            r_rf_write_en   <= 1'b0;
            r_grant_mul     <= 1'b0;
        end
    end

    assign o_stall_pipe    = w_stall;
    assign o_rf_write_en   = r_rf_write_en;
    assign o_rf_write_reg  = r_rf_write_reg;
    assign o_rf_write_data = r_rf_write_data;
    assign o_grant_mul     = r_grant_mul;
    assign o_fifo_count    = r_count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts the state after each
// edge, and a monitor pops the predictions and compares them.
module tb_wb_port_arbiter;

    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned CNT_W    = 3;

    logic             clk = 1'b0;
    logic             i_reset = 1'b0;
    logic             i_pipe_reg_write = 1'b0;
    logic [4:0]       i_pipe_write_reg = '0;
    logic [31:0]      i_pipe_write_data = '0;
    logic             i_mul_valid = 1'b0;
    logic             o_mul_ready;
    logic [4:0]       i_mul_write_reg = '0;
    logic [31:0]      i_mul_write_data = '0;
    logic             o_stall_pipe;
    logic             o_rf_write_en;
    logic [4:0]       o_rf_write_reg;
    logic [31:0]      o_rf_write_data;
    logic             o_grant_mul;
    logic [CNT_W-1:0] o_fifo_count;

    wb_port_arbiter #(
        .DEPTH   (DEPTH),
        .MAX_WAIT(MAX_WAIT),
        .CNT_W   (CNT_W)
    ) u_dut (
        .i_clock          (clk),
        .i_reset          (i_reset),
        .i_pipe_reg_write (i_pipe_reg_write),
        .i_pipe_write_reg (i_pipe_write_reg),
        .i_pipe_write_data(i_pipe_write_data),
        .i_mul_valid      (i_mul_valid),
        .o_mul_ready      (o_mul_ready),
        .i_mul_write_reg  (i_mul_write_reg),
        .i_mul_write_data (i_mul_write_data),
        .o_stall_pipe     (o_stall_pipe),
        .o_rf_write_en    (o_rf_write_en),
        .o_rf_write_reg   (o_rf_write_reg),
        .o_rf_write_data  (o_rf_write_data),
        .o_grant_mul      (o_grant_mul),
        .o_fifo_count     (o_fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [4:0]  rg;
        logic [31:0] data;
        logic        gm;
        int          count;
        logic        ready;
        logic        stall;
    } exp_t;

    typedef struct {
        logic [4:0]  rg;
        logic [31:0] d;
    } ent_t;

    exp_t exp_q[$];
    ent_t mq[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference-model state
    int          waited = 0;
    logic        e_en = 1'b0;
    logic [4:0]  e_reg = '0;
    logic [31:0] e_data = '0;
    logic        e_gm = 1'b0;

    // Upstream sources: each holds its offer until the model says it was taken
    logic        p_pend = 1'b0;
    logic [4:0]  p_reg = '0;
    logic [31:0] p_data = '0;
    logic        m_pend = 1'b0;
    logic [4:0]  m_reg = '0;
    logic [31:0] m_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t r;
        #1;
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk("rf_write_en", 32'(o_rf_write_en), 32'(r.en));
            chk("rf_write_reg", 32'(o_rf_write_reg), 32'(r.rg));
            chk("rf_write_data", o_rf_write_data, r.data);
            chk("grant_mul", 32'(o_grant_mul), 32'(r.gm));
            chk("fifo_count", 32'(o_fifo_count), 32'(r.count));
            chk("mul_ready", 32'(o_mul_ready), 32'(r.ready));
            chk("stall_pipe", 32'(o_stall_pipe), 32'(r.stall));
        end
    end

    // Drive one cycle of inputs, advance the model across the coming edge, queue the prediction.
    task automatic step(input bit rst);
        exp_t r;
        ent_t h;
        int   pre_sz;
        bit   stall;
        bit   gp;
        bit   gf;
        bit   push;
        @(negedge clk);
        i_reset           = rst;
        i_pipe_reg_write  = p_pend;
        i_pipe_write_reg  = p_reg;
        i_pipe_write_data = p_data;
        i_mul_valid       = m_pend;
        i_mul_write_reg   = m_reg;
        i_mul_write_data  = m_data;
        if (rst) begin
            mq.delete();
            waited = 0;
            e_en = 1'b0;
            e_reg = '0;
            e_data = '0;
            e_gm = 1'b0;
        end else begin
            pre_sz = mq.size();
            stall  = (pre_sz != 0) && (waited == MAX_WAIT);
            gp     = p_pend && !stall;
            gf     = !gp && (pre_sz != 0);
            push   = m_pend && (pre_sz < DEPTH);
            if (gp) begin
                e_en = (p_reg != 0);
                e_reg = p_reg;
                e_data = p_data;
                e_gm = 1'b0;
                p_pend = 1'b0;
            end else if (gf) begin
                h = mq.pop_front();
                e_en = (h.rg != 0);
                e_reg = h.rg;
                e_data = h.d;
                e_gm = 1'b1;
            end else begin
                e_en = 1'b0;
                e_gm = 1'b0;
            end
            if (pre_sz == 0 || gf) waited = 0;
            else if (waited < MAX_WAIT) waited = waited + 1;
            if (push) begin
                mq.push_back('{rg: m_reg, d: m_data});
                m_pend = 1'b0;
            end
        end
        r.en    = e_en;
        r.rg    = e_reg;
        r.data  = e_data;
        r.gm    = e_gm;
        r.count = mq.size();
        r.ready = (mq.size() < DEPTH);
        r.stall = (mq.size() != 0) && (waited == MAX_WAIT);
        exp_q.push_back(r);
    endtask

    task automatic gen(input int pipe_pct, input int mul_pct);
        if (!p_pend && $urandom_range(0, 99) < pipe_pct) begin
            p_pend = 1'b1;
            p_reg  = 5'($urandom);
            p_data = $urandom;
        end
        if (!m_pend && $urandom_range(0, 99) < mul_pct) begin
            m_pend = 1'b1;
            m_reg  = 5'($urandom);
            m_data = $urandom;
        end
    endtask

    initial begin
        step(1);
        step(1);

        // Single pipe write, then idle
        p_pend = 1'b1; p_reg = 5'd5; p_data = 32'h0000_00AA;
        repeat (3) step(0);

        // Lone multiply result with the pipe idle
        m_pend = 1'b1; m_reg = 5'd9; m_data = 32'h1234_5678;
        repeat (4) step(0);

        // Continuous pipe writes with one waiting multiply result -> one forced stall
        m_pend = 1'b1; m_reg = 5'd3; m_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 12; i++) begin
            if (!p_pend) begin
                p_pend = 1'b1; p_reg = 5'd7; p_data = 32'(i);
            end
            step(0);
        end
        repeat (3) step(0);

        // Pipe busy, three results into a two-entry FIFO
        for (int i = 0, k = 0; i < 20; i++) begin
            if (!p_pend) begin
                p_pend = 1'b1; p_reg = 5'd11; p_data = 32'h100 + 32'(i);
            end
            if (!m_pend && k < 3) begin
                m_pend = 1'b1; m_reg = 5'(20 + k); m_data = 32'hA000 + 32'(k);
                k++;
            end
            step(0);
        end
        p_pend = 1'b0;
        repeat (6) step(0);

        // Writes to $0 from both sources
        p_pend = 1'b1; p_reg = 5'd0; p_data = 32'd77;
        m_pend = 1'b1; m_reg = 5'd0; m_data = 32'd88;
        repeat (4) step(0);

        // Two entries queued, then reset discards them
        for (int i = 0, k = 0; i < 3; i++) begin
            if (!p_pend) begin
                p_pend = 1'b1; p_reg = 5'd12; p_data = 32'h200 + 32'(i);
            end
            if (!m_pend && k < 2) begin
                m_pend = 1'b1; m_reg = 5'(25 + k); m_data = 32'hB000 + 32'(k);
                k++;
            end
            step(0);
        end
        p_pend = 1'b0;
        step(1);
        repeat (4) step(0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            gen(70, 45);
            step($urandom_range(0, 199) == 0);
        end
        p_pend = 1'b0;
        m_pend = 1'b0;
        repeat (8) step(0);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
